// File: rtl/serial_bus_arbiter.sv
// Two-master arbiter for the shared serial system bus with a grant watchdog.
// Optional macro ROUND_ROBIN_EN: contention goes to the master that did not own the bus last.
module serial_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_done,
    input  logic       m2_done,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       msel,
    output logic       bus_busy,
    output logic       timeout,
    output logic [1:0] o_state,
    output logic       o_last_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT1  = 2'd1,
        GRANT2  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic             r_m1_grant;
    logic             r_m2_grant;
    logic             r_msel;
    logic             r_busy;
    logic             r_timeout;
    logic             r_last_owner;   // 0 = master 1, 1 = master 2
    logic [CNT_W-1:0] r_cnt;

    logic w_pick_m1;
    logic w_pick_m2;
    logic w_owner_done;
    logic w_owner_req;

`ifdef ROUND_ROBIN_EN
    assign w_pick_m1 = m1_req && (!m2_req || r_last_owner);
`else
    assign w_pick_m1 = m1_req;
`endif
    assign w_pick_m2 = m2_req && !w_pick_m1;

    // Only the current owner's done/req matter; the other master's are ignored.
    assign w_owner_done = (r_state == GRANT1) ? m1_done : m2_done;
    assign w_owner_req  = (r_state == GRANT1) ? m1_req  : m2_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_m1_grant   <= 1'b0;
            r_m2_grant   <= 1'b0;
            r_msel       <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_m1) begin
                        r_state      <= GRANT1;
                        r_m1_grant   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_msel       <= 1'b0;
                        r_last_owner <= 1'b0;
                        r_cnt        <= '0;
                    end else if (w_pick_m2) begin
                        r_state      <= GRANT2;
                        r_m2_grant   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_msel       <= 1'b1;
                        r_last_owner <= 1'b1;
                        r_cnt        <= '0;
                    end
                end
                GRANT1, GRANT2: begin
                    // Done takes precedence over the watchdog in the same cycle.
                    if (w_owner_done || !w_owner_req || (r_cnt == TMAX)) begin
                        r_state    <= RELEASE;
                        r_m1_grant <= 1'b0;
                        r_m2_grant <= 1'b0;
                        r_busy     <= 1'b0;
                        r_timeout  <= !w_owner_done && w_owner_req;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m1_grant     = r_m1_grant;
    assign m2_grant     = r_m2_grant;
    assign msel         = r_msel;
    assign bus_busy     = r_busy;
    assign timeout      = r_timeout;
    assign o_state      = r_state;
    assign o_last_owner = r_last_owner;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: main instance (TIMEOUT 64) and watchdog instance (TIMEOUT 8).
module tb_serial_bus_arbiter;

    logic clk;
    logic reset;

    logic a_m1_req, a_m2_req, a_m1_done, a_m2_done;
    logic a_m1_grant, a_m2_grant, a_msel, a_busy, a_timeout, a_last;
    logic [1:0] a_state;

    logic b_m1_req, b_m2_req, b_m1_done, b_m2_done;
    logic b_m1_grant, b_m2_grant, b_msel, b_busy, b_timeout, b_last;
    logic [1:0] b_state;

    int errors = 0;
    int checks = 0;

    serial_bus_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .m1_req(a_m1_req), .m2_req(a_m2_req),
        .m1_done(a_m1_done), .m2_done(a_m2_done),
        .m1_grant(a_m1_grant), .m2_grant(a_m2_grant),
        .msel(a_msel), .bus_busy(a_busy), .timeout(a_timeout),
        .o_state(a_state), .o_last_owner(a_last)
    );

    serial_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) u_wd (
        .clk(clk), .reset(reset),
        .m1_req(b_m1_req), .m2_req(b_m2_req),
        .m1_done(b_m1_done), .m2_done(b_m2_done),
        .m1_grant(b_m1_grant), .m2_grant(b_m2_grant),
        .msel(b_msel), .bus_busy(b_busy), .timeout(b_timeout),
        .o_state(b_state), .o_last_owner(b_last)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        a_m1_req = 1'b1; a_m2_req = 1'b0; a_m1_done = 1'b0; a_m2_done = 1'b0;
        b_m1_req = 1'b0; b_m2_req = 1'b0; b_m1_done = 1'b0; b_m2_done = 1'b0;

        // Reset held with a request pending: everything idle.
        step(); step(); step();
        check("rst_m1_grant", {7'd0, a_m1_grant}, 8'd0);
        check("rst_m2_grant", {7'd0, a_m2_grant}, 8'd0);
        check("rst_msel",     {7'd0, a_msel},     8'd0);
        check("rst_busy",     {7'd0, a_busy},     8'd0);
        check("rst_timeout",  {7'd0, a_timeout},  8'd0);
        check("rst_state",    {6'd0, a_state},    8'd0);
        check("rst_last",     {7'd0, a_last},     8'd1);

        // Release reset in cycle 0; grant one cycle later.
        reset = 1'b1;
        step();
        check("rel_m1_grant", {7'd0, a_m1_grant}, 8'd1);
        check("rel_msel",     {7'd0, a_msel},     8'd0);
        check("rel_busy",     {7'd0, a_busy},     8'd1);
        a_m1_req = 1'b0;
        step();
        check("wd_release",   {7'd0, a_m1_grant}, 8'd0);
        check("wd_tmo",       {7'd0, a_timeout},  8'd0);
        check("wd_state",     {6'd0, a_state},    8'd3);
        step();
        check("wd_idle",      {6'd0, a_state},    8'd0);

        // Single transfer from master 2, done in cycle 20.
        a_m2_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("st_m2_grant", {7'd0, a_m2_grant}, 8'd1);
            check("st_m1_grant", {7'd0, a_m1_grant}, 8'd0);
            check("st_tmo",      {7'd0, a_timeout},  8'd0);
            if (k == 20) a_m2_done = 1'b1;
        end
        check("st_msel", {7'd0, a_msel}, 8'd1);
        step();
        a_m2_done = 1'b0;
        check("st_rel_grant", {7'd0, a_m2_grant}, 8'd0);
        check("st_rel_state", {6'd0, a_state},    8'd3);
        check("st_rel_msel",  {7'd0, a_msel},     8'd1);
        check("st_rel_busy",  {7'd0, a_busy},     8'd0);
        check("st_rel_tmo",   {7'd0, a_timeout},  8'd0);
        a_m2_req = 1'b0;
        step();
        check("st_idle_state", {6'd0, a_state}, 8'd0);
        check("st_idle_msel",  {7'd0, a_msel},  8'd1);
        check("st_last",       {7'd0, a_last},  8'd1);

        // Contention: both requesting, m1 finishes on its 10th granted cycle.
        a_m1_req = 1'b1; a_m2_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("ct_m1_grant", {7'd0, a_m1_grant}, 8'd1);
            check("ct_m2_grant", {7'd0, a_m2_grant}, 8'd0);
            if (k == 10) a_m1_done = 1'b1;
        end
        step();
        a_m1_done = 1'b0;
        check("ct_rel_m1", {7'd0, a_m1_grant}, 8'd0);
        check("ct_rel_m2", {7'd0, a_m2_grant}, 8'd0);
        step();
        check("ct_idle_m1",    {7'd0, a_m1_grant}, 8'd0);
        check("ct_idle_m2",    {7'd0, a_m2_grant}, 8'd0);
        check("ct_idle_state", {6'd0, a_state},    8'd0);
        step();
`ifdef ROUND_ROBIN_EN
        check("ct2_m2_grant", {7'd0, a_m2_grant}, 8'd1);
        check("ct2_m1_grant", {7'd0, a_m1_grant}, 8'd0);
        check("ct2_msel",     {7'd0, a_msel},     8'd1);
`else
        check("ct2_m1_grant", {7'd0, a_m1_grant}, 8'd1);
        check("ct2_m2_grant", {7'd0, a_m2_grant}, 8'd0);
        check("ct2_msel",     {7'd0, a_msel},     8'd0);

        // Non-owner done while m1 owns the bus is ignored.
        a_m2_done = 1'b1;
        step();
        a_m2_done = 1'b0;
        check("nd_m1_grant", {7'd0, a_m1_grant}, 8'd1);
        check("nd_state",    {6'd0, a_state},    8'd1);
        step();
        check("nd_m1_grant2", {7'd0, a_m1_grant}, 8'd1);

        // Asynchronous reset mid-grant.
        reset = 1'b0;
        #1;
        check("ar_m1_grant", {7'd0, a_m1_grant}, 8'd0);
        check("ar_msel",     {7'd0, a_msel},     8'd0);
        check("ar_busy",     {7'd0, a_busy},     8'd0);
        check("ar_tmo",      {7'd0, a_timeout},  8'd0);
`endif
        reset    = 1'b0;
        a_m1_req = 1'b0; a_m2_req = 1'b0;
        step(); step();
        reset = 1'b1;
        step();

        // Watchdog instance: m1 holds request with no done.
        b_m1_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("wdg_grant", {7'd0, b_m1_grant}, 8'd1);
            check("wdg_tmo0",  {7'd0, b_timeout},  8'd0);
        end
        step();
        check("wdg_drop",  {7'd0, b_m1_grant}, 8'd0);
        check("wdg_tmo1",  {7'd0, b_timeout},  8'd1);
        check("wdg_state", {6'd0, b_state},    8'd3);
        step();
        check("wdg_tmo_clr", {7'd0, b_timeout}, 8'd0);
        check("wdg_idle",    {6'd0, b_state},   8'd0);
        check("wdg_idle_gr", {7'd0, b_m1_grant}, 8'd0);
        step();
        check("wdg_regrant", {7'd0, b_m1_grant}, 8'd1);

        // Done on the 8th granted cycle beats the watchdog.
        for (int k = 2; k <= 8; k++) begin
            step();
            check("dvt_grant", {7'd0, b_m1_grant}, 8'd1);
        end
        b_m1_done = 1'b1;
        step();
        b_m1_done = 1'b0;
        check("dvt_drop",  {7'd0, b_m1_grant}, 8'd0);
        check("dvt_tmo",   {7'd0, b_timeout},  8'd0);
        check("dvt_state", {6'd0, b_state},    8'd3);
        b_m1_req = 1'b0;
        step();
        check("dvt_idle", {6'd0, b_state}, 8'd0);
        check("dvt_tmo2", {7'd0, b_timeout}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
